// File: rtl/uart_rx_port.sv
// uart_rx_port
// ------------
// Memory-mapped 8N1 UART receiver for the slurm16 peripheral bus. The
// asynchronous UART_RX pin is synchronised, bits are timed with a down-counter
// derived from CLOCK_FREQ/BAUD_RATE, start and stop bits are validated, and
// good bytes are queued in a small circular FIFO that the CPU drains through
// two register addresses.
//
// Ports
//   clk         system clock
//   RST         asynchronous, active-high reset
//   UART_RX     serial input, idle high, asynchronous to clk
//   ADDRESS     register select; only ADDRESS[0] is decoded
//                 0: DATA   {8'h00, head byte}, a read pops a non-empty FIFO
//                 1: STATUS {12'h000, overrun, frame_err, full, not_empty},
//                    a read clears overrun and frame_err
//   RD          one-cycle read strobe qualified by ADDRESS
//   DATA_OUT    registered read data, valid the cycle after RD, held until
//               the next RD
//   IRQ         high while the FIFO holds at least one byte
//   state_dbg_o receiver FSM state, for observation only
//
// Bus handshake: there is no valid/ready pair. RD is a single-cycle request
// that is always accepted; DATA_OUT carries its response from the next cycle
// and holds it until the following RD.
module uart_rx_port #(
    parameter int CLOCK_FREQ = 6000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        UART_RX,
    input  logic [3:0]  ADDRESS,
    input  logic        RD,
    output logic [15:0] DATA_OUT,
    output logic        IRQ,
    output logic [2:0]  state_dbg_o
);

    localparam int BIT_CYCLES  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
    localparam int PW          = $clog2(FIFO_DEPTH);
    localparam int NW          = PW + 1;

    localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(BIT_CYCLES - 1);
    localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_WAITHI = 3'd4
    } state_t;

    // Two-stage synchroniser, idle-high so reset does not look like a start bit
    logic rx_meta_q, rxs_q;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [NW-1:0] count_q, count_d;

    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic [15:0]   data_out_q, data_out_d;

    logic push, pop, set_ovr, set_fe;
    logic data_rd, status_rd, cnt_zero, not_empty, full;

    logic unused_addr;
    assign unused_addr = ^ADDRESS[3:1];

    assign not_empty = (count_q != '0);
    assign full      = (count_q == DEPTH_N);
    assign data_rd   = RD && !ADDRESS[0];
    assign status_rd = RD &&  ADDRESS[0];
    assign pop       = data_rd && not_empty;
    assign cnt_zero  = (cnt_q == '0);

    assign DATA_OUT    = data_out_q;
    assign IRQ         = not_empty;
    assign state_dbg_o = state_q;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= UART_RX;
            rxs_q     <= rx_meta_q;
        end
    end

    // Receiver FSM: next state and datapath controls
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        set_ovr = 1'b0;
        set_fe  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    cnt_d   = HALF_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_zero) begin
                    if (!rxs_q) begin
                        idx_d   = 3'd0;
                        cnt_d   = BIT_LOAD;
                        state_d = S_DATA;
                    end else begin
                        // Line went back high by mid start bit: a glitch
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    shift_d[idx_q] = rxs_q;
                    cnt_d          = BIT_LOAD;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_zero) begin
                    if (rxs_q) begin
                        // A same-cycle pop frees the slot this push needs
                        if (full && !pop) begin
                            set_ovr = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        set_fe  = 1'b1;
                        state_d = S_WAITHI;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAITHI: begin
                // Break or long low line: wait for idle before re-arming
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Register reads, FIFO occupancy and sticky flags
    always_comb begin
        data_out_d = data_out_q;
        if (status_rd) begin
            data_out_d = {12'h000, overrun_q, frame_err_q, full, not_empty};
        end else if (data_rd) begin
            data_out_d = not_empty ? {8'h00, mem_q[rd_ptr_q]} : 16'h0000;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + NW'(1);
        end else if (pop && !push) begin
            count_d = count_q - NW'(1);
        end

        // A flag raised in the same cycle as a STATUS read survives the clear
        overrun_d   = set_ovr | (overrun_q   & !status_rd);
        frame_err_d = set_fe  | (frame_err_q & !status_rd);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            data_out_q  <= 16'h0000;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            data_out_q  <= data_out_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

endmodule
